// File: rtl/cla_pipelined_subtractor_if.sv
// Stream interface for the pipelined CLA subtractor: operand side and result side.
// Handshake: a beat moves when valid && ready at a rising clock edge. The source holds
// valid and its data stable until the beat moves, and ready never depends on valid.
interface cla_pipelined_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/cla_pipelined_subtractor.sv
// Pipelined subtractor: diff = a + ~b + ~bin, one 4-bit lookahead group per stage,
// with the group carry registered between stages and a single global stall enable.
module cla_pipelined_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  cla_pipelined_subtractor_if.slave    bus
);
  localparam int NSTAGE = WIDTH / 4;
  localparam int NOPS   = (NSTAGE > 1) ? NSTAGE - 1 : 1;
  localparam int OPW    = (WIDTH > 4) ? WIDTH - 4 : 1;

  function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                      input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  logic             en;
  logic             valid_q [NSTAGE];
  logic [WIDTH-1:0] sum_q   [NSTAGE];
  logic             carry_q [NOPS];
  logic [OPW-1:0]   opa_q   [NOPS];
  logic [OPW-1:0]   opnb_q  [NOPS];
  logic             bout_q;
  logic             ovf_q;

  assign en            = !valid_q[NSTAGE-1] || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[NSTAGE-1];
  assign bus.diff      = sum_q[NSTAGE-1];
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

  genvar k;
  for (k = 0; k < NSTAGE; k++) begin : g_stage
    logic [3:0]       ga, gnb, gp, gg, gs;
    logic [4:0]       gc;
    logic             gcin, v_in, ld;
    logic [WIDTH-1:0] sum_base, sum_d;

    if (k == 0) begin : g_first
      assign ga       = bus.a[3:0];
      assign gnb      = ~bus.b[3:0];
      assign gcin     = ~bus.bin;
      assign v_in     = bus.in_valid;
      assign ld       = en && bus.in_valid;
      assign sum_base = '0;
    end else begin : g_next
      // Upper operand bits arrive pre-shifted, so this group always sits in bits [3:0].
      assign ga       = opa_q[k-1][3:0];
      assign gnb      = opnb_q[k-1][3:0];
      assign gcin     = carry_q[k-1];
      assign v_in     = valid_q[k-1];
      assign ld       = en;
      assign sum_base = sum_q[k-1];
    end

    assign gp = ga ^ gnb;
    assign gg = ga & gnb;
    assign gc = cla4(gp, gg, gcin);
    assign gs = gp ^ gc[3:0];

    always_comb begin
      sum_d          = sum_base;
      sum_d[4*k +: 4] = gs;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
      end else if (en) begin
        valid_q[k] <= v_in;
        if (ld) sum_q[k] <= sum_d;
      end
    end

    if (k < NSTAGE - 1) begin : g_carry
      logic [OPW-1:0] opa_d, opnb_d;
      if (k == 0) begin : g_load
        assign opa_d  = OPW'(bus.a >> 4);
        assign opnb_d = OPW'((~bus.b) >> 4);
      end else begin : g_shift
        assign opa_d  = opa_q[k-1] >> 4;
        assign opnb_d = opnb_q[k-1] >> 4;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          carry_q[k] <= 1'b0;
          opa_q[k]   <= '0;
          opnb_q[k]  <= '0;
        end else if (ld) begin
          carry_q[k] <= gc[4];
          opa_q[k]   <= opa_d;
          opnb_q[k]  <= opnb_d;
        end
      end
    end else begin : g_last
      // Borrow and overflow are stored already resolved so both read 0 straight out of reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          bout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (ld) begin
          bout_q <= ~gc[4];
          ovf_q  <= gc[3] ^ gc[4];
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// Bench for cla_pipelined_subtractor (WIDTH=16): directed vector table, reset and latency
// sequences, and random streams scored against an arithmetic reference model.
module tb_cla_pipelined_subtractor;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_pipelined_subtractor_if #(.WIDTH(W)) bus ();

  cla_pipelined_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] prev_res;
  logic         prev_stall = 1'b0;
  int           in_cnt = 0, out_cnt = 0;
  int           first_in_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer subtraction, unsigned for borrow and signed for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
    int u, s;
    logic [W-1:0] d;
    u = int'(a) - int'(b) - int'(bin);
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d = u[W-1:0];
    return {(u < 0), ((s > 32767) || (s < -32768)), d};
  endfunction

  // Scoreboard: counts every transfer on both sides and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'((!bus.out_valid) || bus.out_ready));
      if (prev_stall)
        chk("stall_hold", {bus.out_valid, bus.bout, bus.ovf, bus.diff}, {1'b1, prev_res});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: got %0h expected no output (cycle %0d)",
                   {bus.bout, bus.ovf, bus.diff}, cyc);
        end else begin
          chk("result", {bus.bout, bus.ovf, bus.diff}, exp_q.pop_front());
        end
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bin));
        if (in_cnt == 0) first_in_cyc = cyc;
        in_cnt++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = {bus.bout, bus.ovf, bus.diff};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand set into an idle pipe and time the result (called at a negedge).
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output int lat, output logic [W+1:0] res);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {bus.bout, bus.ovf, bus.diff};
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    int lat, sent, guard;
    logic acc;
    logic [W+1:0] res;

    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed table
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i].a, vecs[i].b, vecs[i].bin, lat, res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_result", i), 32'(res),
          32'({vecs[i].bout, vecs[i].ovf, vecs[i].diff}));
    end
    drain("table_drain");

    // Back-to-back random stream with the sink always ready
    in_cnt = 0;
    out_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom_range(0, 16'hFFFF));
      bus.b = W'($urandom_range(0, 16'hFFFF));
      bus.bin = 1'($urandom_range(0, 1));
      tick();
    end
    bus.in_valid = 1'b0;
    drain("s1_drain");
    chk("s1_count", 32'(out_cnt), 32'd20);
    chk("s1_first_latency", 32'(first_out_cyc - first_in_cyc), 32'd4);
    chk("s1_consecutive", 32'(last_out_cyc - first_out_cyc), 32'd19);

    // Random stream with ~40% backpressure
    in_cnt = 0;
    out_cnt = 0;
    sent = 0;
    guard = 0;
    tick();
    bus.in_valid = 1'b1;
    bus.a = W'($urandom_range(0, 16'hFFFF));
    bus.b = W'($urandom_range(0, 16'hFFFF));
    bus.bin = 1'($urandom_range(0, 1));
    bus.out_ready = ($urandom_range(0, 99) >= 40);
    while (sent < 20 && guard < 2000) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
      guard++;
      if (acc) begin
        sent++;
        bus.a = W'($urandom_range(0, 16'hFFFF));
        bus.b = W'($urandom_range(0, 16'hFFFF));
        bus.bin = 1'($urandom_range(0, 1));
      end
      bus.in_valid = (sent < 20);
      bus.out_ready = ($urandom_range(0, 99) >= 40);
    end
    chk("s2_sent", 32'(sent), 32'd20);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("s2_drain");
    chk("s2_count", 32'(out_cnt), 32'd20);

    // Reset while three results are in flight
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'(16'h0100 * (i + 1));
      bus.b = W'(i);
      bus.bin = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    end
    send_one(16'h0005, 16'h0003, 1'b0, lat, res);
    chk("post_flush_latency", 32'(lat), 32'd4);
    chk("post_flush_result", 32'(res), 32'h00002);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_pipelined_subtractor.md
Name: cla_pipelined_subtractor

Overview:
- Pipelined, parameterized-width subtractor: computes diff = a - b - bin as a + ~b + ~bin using 4-bit carry-lookahead groups.
- One 4-bit group is resolved per pipeline stage, and the group carry is registered between stages.
- It is the inverse-direction companion to the team's 4-bit CLA adder. It sits in datapaths that need wide subtraction at high clock rate, with a valid/ready stream on both sides.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NSTAGE, WIDTH/4, derived; not overridable. Number of pipeline stages and the latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out; 1 when unsigned a < b + bin
- ovf  output  1  signed overflow of the two's-complement subtraction

Behaviour:
- Global pipeline enable: en = !out_valid || out_ready. in_ready = en, combinational; it never depends on in_valid.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - When en=0, every stage register holds its value.
- Stage 0 (on input transfer):
  - Per bit: p = a[i] ^ ~b[i] and g = a[i] & ~b[i], with group carry-in c0 = ~bin.
  - Carries c1..c4 are computed with full lookahead equations, not a ripple chain.
  - Sum bits = p ^ c.
  - Registered into stage 0: sum bits [3:0], carry c4, the remaining operand bits a[WIDTH-1:4] and ~b[WIDTH-1:4], and a valid bit.
- Stage k (1..NSTAGE-1):
  - Same 4-bit lookahead on operand bits [4k+3:4k], with carry-in taken from the previous stage's registered carry.
  - Passes forward the accumulated lower sum bits and the unconsumed upper operand bits.
- Valid bits:
  - Each stage's valid bit shifts forward when en=1.
  - Stage 0's valid loads in_valid && in_ready.
  - Bubbles propagate as invalid slots; they are not collapsed.
- Final stage outputs:
  - diff = accumulated sum.
  - bout = ~(final carry).
  - ovf = carry into MSB XOR carry out of MSB; the final stage must register the MSB carry-in.
  - out_valid = last stage valid bit.
- Latency and throughput:
  - Exactly NSTAGE cycles from input transfer to out_valid, with no stalls (WIDTH=16: 4 cycles).
  - Throughput of one result per cycle while out_ready=1.
- Stall: out_valid=1 with out_ready=0 freezes the entire pipeline. diff, bout and ovf stay stable until the output transfer.
- Simultaneous events: output transfer and input transfer in the same cycle are legal and lose no data.
- Reset values:
  - All valid bits 0, so out_valid=0.
  - diff=0, bout=0, ovf=0, and all internal data registers 0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-operation: every in-flight result is discarded. No out_valid is asserted for operands accepted before reset.
- Degenerate case: WIDTH=4 gives a single stage with 1-cycle latency.
- Outputs with out_valid=0 are don't-care for checking, but they must not be X after reset.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0034, bin=0, out_ready=1 -> 4 cycles later: diff=0x1200, bout=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Also a=0x0010, b=0x0000, bin=1 -> diff=0x000F, bout=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- Stream 20 random back-to-back operand sets with out_ready=1 -> 20 consecutive out_valid cycles, in order, each matching the reference model a-b-bin; the first result appears 4 cycles after the first input.
- Same stream with out_ready randomly low ~40% of cycles -> in_ready tracks !out_valid||out_ready; no result dropped or duplicated; outputs stable while stalled.
- Accept 3 operand sets, assert rst for 1 cycle before any result emerges -> out_valid stays 0 until new input; next input 0x0005-0x0003 -> diff=0x0002 after exactly 4 cycles.
